// File: rtl/partition_mon_pkg.sv
// Shared constants for the partition error monitor.
// State codes, width helpers and a clog2 usable in parameter math.
package partition_mon_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int N_IN_DEF  = 7;
  localparam int N_OUT_DEF = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int w_hdv(input int n_out);
    return clog2(n_out + 1);
  endfunction

  function automatic int w_err(input int n_in);
    return n_in + 1;
  endfunction

  function automatic int w_hd(input int n_in, input int n_out);
    return n_in + 1 + clog2(n_out + 1);
  endfunction

  function automatic int w_abs(input int n_in, input int n_out);
    return n_in + n_out;
  endfunction

endpackage

// File: rtl/partition_error_monitor_if.sv
// Vector/response bus between the monitor and a partition pair.
// master = monitor side, slave = partition side.
interface partition_error_monitor_if #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 4
);
  logic [N_IN-1:0]  pi;
  logic [N_OUT-1:0] po_exact;
  logic [N_OUT-1:0] po_approx;

  modport master (
    output pi,
    input  po_exact,
    input  po_approx
  );

  modport slave (
    input  pi,
    output po_exact,
    output po_approx
  );
endinterface

// File: rtl/partition_err_metric.sv
// Per-vector error metrics for one exact/approx response pair.
// Pure combinational; shared with the golden model wrapper.
module partition_err_metric
  import partition_mon_pkg::*;
#(
  parameter int N_OUT = 4,
  localparam int W_HDV = w_hdv(N_OUT)
) (
  input  logic [N_OUT-1:0] po_exact,
  input  logic [N_OUT-1:0] po_approx,
  output logic [W_HDV-1:0] hd,
  output logic [N_OUT-1:0] ad,
  output logic             mismatch
);

  logic [N_OUT-1:0] diff;

  always_comb begin
    diff = po_exact ^ po_approx;
    hd   = '0;
    for (int i = 0; i < N_OUT; i++)
      hd = hd + W_HDV'(diff[i]);
    if (po_exact >= po_approx)
      ad = po_exact - po_approx;
    else
      ad = po_approx - po_exact;
    mismatch = |diff;
  end

endmodule

// File: rtl/partition_error_monitor.sv
// Exhaustive sweep driver and error accumulator for a partition pair.
// Responses are qualified by a valid bit delayed LAT cycles.
module partition_error_monitor
  import partition_mon_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int LAT   = 1,
  localparam int W_ERR = w_err(N_IN),
  localparam int W_HD  = w_hd(N_IN, N_OUT),
  localparam int W_ABS = w_abs(N_IN, N_OUT),
  localparam int W_HDV = w_hdv(N_OUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  partition_error_monitor_if.master part,
  output logic                  busy,
  output logic                  done,
  output logic [W_ERR-1:0]      err_vec,
  output logic [W_HD-1:0]       hd_sum,
  output logic [W_ABS-1:0]      abs_sum,
  output logic [N_OUT-1:0]      max_abs
);

  localparam longint NV = longint'(1) << N_IN;
  localparam longint MAX_AD = (longint'(1) << N_OUT) - 1;
  localparam int W_DC = (LAT > 1) ? clog2(LAT) : 1;

  if (NV >= (longint'(1) << W_ERR)) begin : g_err_w
    $error("err_vec too narrow for sweep");
  end
  if (NV * N_OUT >= (longint'(1) << W_HD)) begin : g_hd_w
    $error("hd_sum too narrow for sweep");
  end
  if (NV * MAX_AD >= (longint'(1) << W_ABS)) begin : g_abs_w
    $error("abs_sum too narrow for sweep");
  end
  if (LAT < 0) begin : g_lat_w
    $error("LAT must be non-negative");
  end

  logic [1:0]       state;
  logic [N_IN-1:0]  pi_q;
  logic [W_DC-1:0]  dcnt;
  logic             sweep;
  logic             valid;
  logic             last_vec;
  logic             drain_last;
  logic             accept;

  logic [W_HDV-1:0] hd;
  logic [N_OUT-1:0] ad;
  logic             mism;

  assign part.pi    = pi_q;
  assign sweep      = (state == SWEEP);
  assign busy       = sweep | (state == DRAIN);
  assign last_vec   = (pi_q == {N_IN{1'b1}});
  assign drain_last = (int'(dcnt) == LAT - 1);
  assign accept     = start &
                      ((state == IDLE) | (state == DONE));

  // valid bit travels alongside each vector through the DUT latency
  if (LAT == 0) begin : g_comb
    assign valid = sweep;
  end else begin : g_pipe
    logic [LAT-1:0] vsr;
    always_ff @(posedge clk) begin
      if (rst) begin
        vsr <= '0;
      end else begin
        vsr[0] <= sweep;
        for (int i = 1; i < LAT; i++)
          vsr[i] <= vsr[i-1];
      end
    end
    assign valid = vsr[LAT-1];
  end

  partition_err_metric #(
    .N_OUT(N_OUT)
  ) u_metric (
    .po_exact (part.po_exact),
    .po_approx(part.po_approx),
    .hd       (hd),
    .ad       (ad),
    .mismatch (mism)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pi_q  <= '0;
      dcnt  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SWEEP;
            pi_q  <= '0;
          end
        end
        SWEEP: begin
          if (last_vec) begin
            dcnt <= '0;
            if (LAT == 0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            pi_q <= pi_q + N_IN'(1);
          end
        end
        DRAIN: begin
          if (drain_last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + W_DC'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_vec <= '0;
      hd_sum  <= '0;
      abs_sum <= '0;
      max_abs <= '0;
    end else if (valid) begin
      err_vec <= err_vec + W_ERR'(mism);
      hd_sum  <= hd_sum + W_HD'(hd);
      abs_sum <= abs_sum + W_ABS'(ad);
      if (ad > max_abs)
        max_abs <= ad;
    end
  end

endmodule

// File: tb/tb_partition_error_monitor.sv
// Bench for partition_error_monitor: table vectors, random tables
// against a truth-table model, restart and mid-sweep reset cases.
module tb_partition_error_monitor;
  import partition_mon_pkg::*;

  localparam int N_IN  = 7;
  localparam int N_OUT = 4;
  localparam int LAT   = 1;
  localparam int NV    = 1 << N_IN;
  localparam int W_ERR = w_err(N_IN);
  localparam int W_HD  = w_hd(N_IN, N_OUT);
  localparam int W_ABS = w_abs(N_IN, N_OUT);

  typedef struct {
    int err;
    int hd;
    int abs_s;
    int mx;
  } met_t;

  typedef struct {
    int   mode;
    met_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic [W_ERR-1:0] err_vec;
  logic [W_HD-1:0]  hd_sum;
  logic [W_ABS-1:0] abs_sum;
  logic [N_OUT-1:0] max_abs;

  int checks = 0;
  int errors = 0;

  logic [N_OUT-1:0] ex_tbl [NV];
  logic [N_OUT-1:0] ap_tbl [NV];
  logic [N_IN-1:0]  resp_pi;

  partition_error_monitor_if #(
    .N_IN(N_IN), .N_OUT(N_OUT)
  ) part ();

  partition_error_monitor #(
    .N_IN(N_IN), .N_OUT(N_OUT), .LAT(LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .part   (part.master),
    .busy   (busy),
    .done   (done),
    .err_vec(err_vec),
    .hd_sum (hd_sum),
    .abs_sum(abs_sum),
    .max_abs(max_abs)
  );

  always #5 clk = ~clk;

  // partition pair modelled as table lookups behind LAT registers
  if (LAT == 0) begin : g_comb
    assign resp_pi = part.pi;
  end else begin : g_pipe
    logic [N_IN-1:0] sr [LAT];
    always @(posedge clk) begin
      sr[0] <= part.pi;
      for (int i = 1; i < LAT; i++)
        sr[i] <= sr[i-1];
    end
    assign resp_pi = sr[LAT-1];
  end

  assign part.po_exact  = busy ? ex_tbl[resp_pi] : 'x;
  assign part.po_approx = busy ? ap_tbl[resp_pi] : 'x;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pi"}, longint'(part.pi), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_err"}, longint'(err_vec), 0);
    chk({tag, "_hd"}, longint'(hd_sum), 0);
    chk({tag, "_abs"}, longint'(abs_sum), 0);
    chk({tag, "_max"}, longint'(max_abs), 0);
  endtask

  task automatic chk_met(input string tag, input met_t m);
    chk({tag, "_err"}, longint'(err_vec), m.err);
    chk({tag, "_hd"}, longint'(hd_sum), m.hd);
    chk({tag, "_abs"}, longint'(abs_sum), m.abs_s);
    chk({tag, "_max"}, longint'(max_abs), m.mx);
  endtask

  task automatic fill(input int mode);
    for (int v = 0; v < NV; v++) begin
      ex_tbl[v] = N_OUT'(v);
      case (mode)
        0: ap_tbl[v] = ex_tbl[v];
        1: ap_tbl[v] = ex_tbl[v] ^ N_OUT'(1);
        2: ap_tbl[v] = '0;
        3: ap_tbl[v] = ~ex_tbl[v];
        default: begin
          ex_tbl[v] = N_OUT'($urandom);
          if ($urandom_range(0, 3) == 0)
            ap_tbl[v] = ex_tbl[v];
          else
            ap_tbl[v] = N_OUT'($urandom);
        end
      endcase
    end
  endtask

  function automatic met_t model();
    met_t m;
    m = '{0, 0, 0, 0};
    for (int v = 0; v < NV; v++) begin
      int e, a, d;
      e = int'(ex_tbl[v]);
      a = int'(ap_tbl[v]);
      d = (e > a) ? e - a : a - e;
      if (e != a) m.err++;
      m.hd += $countones(ex_tbl[v] ^ ap_tbl[v]);
      m.abs_s += d;
      if (d > m.mx) m.mx = d;
    end
    return m;
  endfunction

  // n counts edges after the start edge; sampling is #1 after each
  task automatic run(input int restart_at, input int abort_at,
                     output int done_at, output int busy_cnt);
    int n;
    n = 0;
    done_at = -1;
    busy_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_at < 0 && n < NV + LAT + 64) begin
      if (busy) busy_cnt++;
      if (done) done_at = n;
      if (n == restart_at) begin
        chk("pi_at_restart", longint'(part.pi), restart_at);
        start = 1'b1;
      end
      if (n == abort_at) begin
        chk("pi_at_reset", longint'(part.pi), abort_at);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero("midrst");
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    if (done_at >= 0) begin
      @(posedge clk); #1;
      chk("done_one_cycle", longint'(done), 0);
    end
  endtask

  vec_t tv [4];
  met_t m;
  int   d_at, b_cnt;

  initial begin
    tv[0] = '{0, '{0,   0,   0,    0}};
    tv[1] = '{1, '{128, 128, 128,  1}};
    tv[2] = '{2, '{120, 256, 960,  15}};
    tv[3] = '{3, '{128, 512, 1024, 15}};

    rst   = 1'b1;
    start = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      fill(tv[i].mode);
      run(-1, -1, d_at, b_cnt);
      chk("done_cycle", d_at, NV + LAT);
      chk("busy_width", b_cnt, NV + LAT);
      chk_met("table", tv[i].exp);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_err", longint'(err_vec), tv[i].exp.err);
    end

    for (int r = 0; r < 4; r++) begin
      fill(4);
      m = model();
      run(-1, -1, d_at, b_cnt);
      chk("rand_done_cycle", d_at, NV + LAT);
      chk_met("rand", m);
    end

    fill(4);
    m = model();
    run(40, -1, d_at, b_cnt);
    chk("ignored_start_done", d_at, NV + LAT);
    chk_met("ignored_start", m);
    run(-1, -1, d_at, b_cnt);
    chk("rerun_done", d_at, NV + LAT);
    chk_met("rerun", m);

    fill(4);
    m = model();
    run(-1, 60, d_at, b_cnt);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset", longint'(busy), 0);
    run(-1, -1, d_at, b_cnt);
    chk("post_reset_done", d_at, NV + LAT);
    chk_met("post_reset", m);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/partition_error_monitor.md
Name: partition_error_monitor

Overview:
- Hardware response side of the exhaustive partition sweep.
- Drives every input vector 0..2^N_IN-1 into a partition pair (exact netlist and approximate netlist) and accumulates error metrics on the returned outputs.
- The metrics are the same ones the approximation flow derives from printed truth tables: mismatching vectors, Hamming distance and absolute error.
- Sits beside the DUT partitions on FPGA/emulation builds, so error evaluation needs no simulator dump.

Parameters:
- N_IN, 7, partition input width; sweep length 2^N_IN.
- N_OUT, 4, partition output width.
- LAT, 1, cycles from pi driven to po_exact/po_approx valid (0 = combinational DUT).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- pi  out  N_IN  vector driven to both partitions.
- po_exact  in  N_OUT  exact partition output.
- po_approx  in  N_OUT  approximate partition output.
- busy  out  1  high during SWEEP and DRAIN.
- done  out  1  one-cycle pulse when results are final.
- err_vec  out  N_IN+1  count of vectors with po_exact != po_approx.
- hd_sum  out  N_IN+1+clog2(N_OUT+1)  sum of per-vector Hamming distances.
- abs_sum  out  N_IN+N_OUT  sum of |po_exact - po_approx| (unsigned operands).
- max_abs  out  N_OUT  maximum per-vector absolute error.

Behaviour:
- Reset (sync, active-high) applies whenever rst is sampled high, including mid-sweep:
  - pi=0, busy=0, done=0, all metric outputs 0, state IDLE.
  - In-flight responses are discarded.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE with start=1 at edge t:
  - Clear all accumulators.
  - Go to SWEEP.
  - Drive pi=0 from t+1.
- SWEEP:
  - pi increments by 1 each cycle.
  - A valid bit enters a LAT-deep shift register alongside each vector.
  - When pi=2^N_IN-1 is driven, the next state is DRAIN (LAT>0) or DONE (LAT=0).
  - pi holds its last value in DRAIN and DONE.
- Sampling: responses are accumulated on any cycle where the delayed valid bit is 1.
  - With LAT=0, the response is sampled in the same cycle the vector is driven.
- DRAIN: lasts exactly LAT cycles until the valid pipeline empties, then DONE.
- Timing: with start sampled at edge t, the last response is accumulated at edge t+2^N_IN+LAT. done is high during the cycle following that edge, for exactly one cycle.
- Results hold their values in DONE until the next accepted start.
- start while busy is ignored (no restart, no clear).
- Per-vector metrics (unsigned):
  - hd = popcount(po_exact ^ po_approx).
  - ad = po_exact >= po_approx ? po_exact - po_approx : po_approx - po_exact.
  - err_vec increments when hd != 0.
  - max_abs updates when ad > max_abs.
- Widths are sized so no accumulator can overflow for the full sweep. Saturation logic is not required; a width assertion is checked at elaboration.
- X on po_* while the valid bit is 0 must not affect the accumulators.

Decomposition:
- Shared package (partition_mon_pkg):
  - state enum {IDLE, SWEEP, DRAIN, DONE}.
  - width constants derived from N_IN/N_OUT.
  - clog2 helper.
- Sub-module partition_err_metric: combinational, takes po_exact/po_approx and produces hd, ad and mismatch. It is reused by the software-side golden model wrapper.

Test Plan:
- Identical partitions (po_approx=po_exact=pi[3:0]), start once -> done at t+129+LAT; err_vec=0, hd_sum=0, abs_sum=0, max_abs=0.
- po_approx = po_exact ^ 4'b0001 with po_exact=pi[3:0] -> err_vec=128, hd_sum=128, abs_sum=128, max_abs=1.
- po_exact=pi[3:0], po_approx=0 -> err_vec=120, hd_sum=256, abs_sum=960, max_abs=15.
- LAT=0 and LAT=3 builds with a matching DUT delay -> identical metrics to the LAT=1 case; done cycle shifts by exactly ΔLAT; busy width = 128+LAT cycles.
- Pulse start at sweep vector 40, then again in DONE -> first pulse ignored; second clears results and reruns, producing identical values.
- Assert rst at vector 60 -> next cycle all outputs 0 and state IDLE; a subsequent start produces full, uncorrupted results.
